// File: rtl/acc_out_port.sv
// Output port FIFO between the CPU accumulator and an external device.
// Each OUT instruction pushes the 4-bit accumulator value into a small FIFO.
// The external device drains the FIFO with a valid/ready handshake.
// When the FIFO is full and nothing drains that cycle, the CPU is told to
// stall. An OUT that arrives anyway is dropped and latched in a sticky
// overflow flag.
module acc_out_port #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               A_Result,
  input  logic                     out_we,
  output logic [3:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push;

  // Handshake decode and next-state for pointers, count and overflow.
  // DEPTH is a power of two, so pointer wrap is the natural roll-over.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    pop      = !empty && out_ready;
    push     = out_we && (!full || pop);
    stall    = out_we && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A refused push in the same cycle as a clear keeps the flag set.
    if (ovf_clr) ovf_d = 1'b0;
    if (stall)   ovf_d = 1'b1;
  end

  // Control state: cleared immediately whenever reset is pulled low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is data only and is never cleared; writes are blocked in reset.
  always_ff @(posedge clk) begin
    if (push && reset) mem_q[wr_ptr_q] <= A_Result;
  end

  // Head of FIFO; forced to zero while empty so it reads 0 out of reset and stays stable.
  always_comb begin
    out_valid = !empty;
    out_data  = empty ? 4'h0 : mem_q[rd_ptr_q];
    count     = count_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_acc_out_port.sv
module tb_acc_out_port;

  logic       clk;
  logic       reset;
  logic [3:0] A_Result;
  logic       out_we;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       stall;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr;

  int total  = 0;
  int passed = 0;

  acc_out_port #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .A_Result  (A_Result),
    .out_we    (out_we),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stall     (stall),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs for this cycle and the outputs expected just before its rising edge.
  typedef struct {
    logic       we;
    logic [3:0] a;
    logic       rdy;
    logic       clr;
    logic [3:0] d;
    logic       v;
    logic [2:0] c;
    logic       st;
    logic       ov;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic we, logic [3:0] a, logic rdy, logic clr,
                              logic [3:0] d, logic v, logic [2:0] c, logic st, logic ov);
    vec_t r;
    r.we = we; r.a = a; r.rdy = rdy; r.clr = clr;
    r.d = d; r.v = v; r.c = c; r.st = st; r.ov = ov;
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    out_we = v.we; A_Result = v.a; out_ready = v.rdy; ovf_clr = v.clr;
    #1;
    if (v.v) chk($sformatf("v%0d.out_data", idx), {4'h0, out_data}, {4'h0, v.d});
    chk($sformatf("v%0d.out_valid", idx), {7'h0, out_valid}, {7'h0, v.v});
    chk($sformatf("v%0d.count", idx),     {5'h0, count},     {5'h0, v.c});
    chk($sformatf("v%0d.stall", idx),     {7'h0, stall},     {7'h0, v.st});
    chk($sformatf("v%0d.overflow", idx),  {7'h0, overflow},  {7'h0, v.ov});
  endtask

  initial begin
    // Vector table: we, A, rdy, clr | data, valid, count, stall, overflow
    // Two pushes, then drain both
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4'h3, 0, 0, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4'h9, 0, 0, 4'h3, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h3, 1, 2, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h3, 1, 2, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h9, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0));
    // Fill to full, refused push sets overflow
    vq.push_back(mk(1, 4'h1, 0, 0, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4'h2, 0, 0, 4'h1, 1, 1, 0, 0));
    vq.push_back(mk(1, 4'h3, 0, 0, 4'h1, 1, 2, 0, 0));
    vq.push_back(mk(1, 4'h4, 0, 0, 4'h1, 1, 3, 0, 0));
    vq.push_back(mk(1, 4'h5, 0, 0, 4'h1, 1, 4, 1, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h1, 1, 4, 0, 1));
    // Full with simultaneous push and pop, then drain 2,3,4,A
    vq.push_back(mk(1, 4'hA, 1, 0, 4'h1, 1, 4, 0, 1));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h2, 1, 4, 0, 1));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h3, 1, 3, 0, 1));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h4, 1, 2, 0, 1));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'hA, 1, 1, 0, 1));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 1));
    // Refill, clear racing a refused push, then clear alone
    vq.push_back(mk(1, 4'h5, 0, 0, 4'h0, 0, 0, 0, 1));
    vq.push_back(mk(1, 4'h6, 0, 0, 4'h5, 1, 1, 0, 1));
    vq.push_back(mk(1, 4'h7, 0, 0, 4'h5, 1, 2, 0, 1));
    vq.push_back(mk(1, 4'h8, 0, 0, 4'h5, 1, 3, 0, 1));
    vq.push_back(mk(1, 4'hB, 0, 1, 4'h5, 1, 4, 1, 1));
    vq.push_back(mk(0, 4'h0, 0, 1, 4'h5, 1, 4, 0, 1));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h5, 1, 4, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h5, 1, 4, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h6, 1, 3, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h7, 1, 2, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h8, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0));
    // Streaming six pushes with ready held high: pointers wrap, count stays <= 1
    vq.push_back(mk(1, 4'hC, 1, 0, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4'hD, 1, 0, 4'hC, 1, 1, 0, 0));
    vq.push_back(mk(1, 4'hE, 1, 0, 4'hD, 1, 1, 0, 0));
    vq.push_back(mk(1, 4'hF, 1, 0, 4'hE, 1, 1, 0, 0));
    vq.push_back(mk(1, 4'h0, 1, 0, 4'hF, 1, 1, 0, 0));
    vq.push_back(mk(1, 4'h1, 1, 0, 4'h0, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'h0, 1, 0, 4'h1, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'h0, 0, 0, 4'h0, 0, 0, 0, 0));

    // Reset state, with an OUT attempted while reset is held
    reset = 1'b0; out_we = 1'b1; A_Result = 4'h7; out_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    chk("rst.count",     {5'h0, count},     8'h0);
    chk("rst.out_valid", {7'h0, out_valid}, 8'h0);
    chk("rst.out_data",  {4'h0, out_data},  8'h0);
    chk("rst.stall",     {7'h0, stall},     8'h0);
    chk("rst.overflow",  {7'h0, overflow},  8'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst.count_held", {5'h0, count}, 8'h0);
    out_we = 1'b0; out_ready = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // Asynchronous reset between edges with three entries stored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_we = 1'b1; A_Result = 4'(i + 2); out_ready = 1'b0;
    end
    @(negedge clk);
    out_we = 1'b0;
    #1;
    chk("arst.count_before", {5'h0, count}, 8'h3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst.count",     {5'h0, count},     8'h0);
    chk("arst.out_valid", {7'h0, out_valid}, 8'h0);
    chk("arst.out_data",  {4'h0, out_data},  8'h0);
    @(negedge clk);
    reset = 1'b1; out_we = 1'b1; A_Result = 4'hF;
    #1;
    chk("arst.count_release", {5'h0, count}, 8'h0);
    @(negedge clk);
    out_we = 1'b0;
    #1;
    chk("arst.head_data",  {4'h0, out_data},  8'h0F);
    chk("arst.head_valid", {7'h0, out_valid}, 8'h1);
    chk("arst.head_count", {5'h0, count},     8'h1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("arst.drained", {5'h0, count}, 8'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/acc_out_port.md
ACC_OUT_PORT -- requirements
Module: acc_out_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
REQ-004 SHALL have port A_Result  input  4  accumulator value to be output.
REQ-005 SHALL have port out_we  input  1  CPU executes an OUT instruction this cycle; push A_Result.
REQ-006 SHALL have port out_data  output  4  head-of-FIFO nibble presented to external device.
REQ-007 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-008 SHALL have port out_ready  input  1  external device accepts out_data this cycle.
REQ-009 SHALL have port stall  output  1  CPU must hold its OUT instruction; push would be lost.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current entry count.
REQ-011 SHALL have port overflow  output  1  sticky flag: a push was dropped.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-013 SHALL implement a DEPTH-entry 4-bit FIFO with write pointer, read pointer, and count registers.
REQ-014 Pop SHALL occur on a rising edge when out_valid=1 and out_ready=1; read pointer advances by one.
REQ-015 Push SHALL occur on a rising edge when out_we=1 and (count<DEPTH or pop occurs that cycle); A_Result written at write pointer, write pointer advances by one.
REQ-016 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 count SHALL be +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-018 Push+pop when count=0 SHALL be impossible (out_valid=0); push proceeds, count becomes 1; no bypass of empty FIFO to out_data in the same cycle.
REQ-019 Push+pop when count=DEPTH SHALL both succeed; count stays DEPTH; new entry lands in freed slot.
REQ-020 out_valid SHALL equal (count!=0); out_data SHALL equal the entry at the read pointer; out_data value when out_valid=0 is don't-care but SHALL be stable.
REQ-021 out_data/out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 stall SHALL be combinational: out_we=1 and count=DEPTH and no pop this cycle.
REQ-023 overflow SHALL set on a rising edge where out_we=1 and the push is refused (stall=1); it SHALL hold until cleared.
REQ-024 ovf_clr=1 SHALL clear overflow on the next edge; if a refused push occurs the same cycle, overflow SHALL be 1 (set wins).
REQ-025 Latency: a pushed nibble SHALL appear on out_data with out_valid=1 one cycle after the push edge when FIFO was empty.
REQ-026 Order SHALL be strict FIFO; no entry duplicated or skipped.

Reset
REQ-027 While reset=0: pointers=0, count=0, out_valid=0, overflow=0, stall=0; pushes and pops ignored.
REQ-028 Reset mid-operation SHALL discard all stored entries; first push after release is the new head.
REQ-029 Storage array contents need not be cleared; out_data SHALL read 4'b0000 out of reset.

Verification
REQ-030 Push 4'h3, 4'h9 on consecutive cycles, out_ready=0 -> count=2, out_data=4'h3, out_valid=1; then out_ready=1 two cycles -> out_data 4'h3 then 4'h9, count 0, out_valid=0.
REQ-031 Push 4'h1..4'h4 (DEPTH=4), out_ready=0, then out_we=1 A_Result=4'h5 -> stall=1, count=4, next edge overflow=1, FIFO holds 1,2,3,4.
REQ-032 Full FIFO, out_we=1 A_Result=4'hA with out_ready=1 -> stall=0, pop 4'h1, count=4, drain order 2,3,4,A.
REQ-033 Push 6 entries with out_ready=1 continuously -> pointers wrap, output sequence matches input order exactly, count never exceeds 1.
REQ-034 overflow=1, assert ovf_clr with refused push same cycle -> overflow=1; ovf_clr alone next cycle -> overflow=0.
REQ-035 Count=3, pull reset=0 asynchronously between edges -> count=0, out_valid=0 immediately; release, push 4'hF -> out_data=4'hF next cycle.
